// File: rtl/fluid_seq_pkg.sv
// Shared types for the planar fluid chain sequencer: stage kinds, FSM states
// and the per-stage configuration record.
package fluid_seq_pkg;

  // Stored dwell field is sized for the widest supported dwell counter.
  localparam int CFG_DWELL_W = 32;

  typedef enum logic [1:0] {
    ST_MIX    = 2'd0,
    ST_HEAT   = 2'd1,
    ST_FILTER = 2'd2,
    ST_BYPASS = 2'd3
  } stage_type_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_WAIT_TEMP,
    S_DWELL,
    S_DRAIN,
    S_FAULT
  } seq_state_t;

  typedef struct packed {
    stage_type_t            stype;
    logic [CFG_DWELL_W-1:0] dwell;
  } stage_cfg_t;

endpackage

// File: rtl/fluid_chain_sequencer_timer.sv
// Loadable down-counter; expire is high during the last cycle of a loaded
// interval, so a load of N spans exactly N cycles.
module seq_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign expire = (cnt == W'(1));

endmodule

// File: rtl/fluid_chain_sequencer.sv
// Sequences one sample plug through a chain of fluidic stages: inlet transfer,
// optional heater wait, actuator dwell, then the outlet drain.
module fluid_chain_sequencer
  import fluid_seq_pkg::*;
#(
  parameter int NUM_STAGES   = 10,
  parameter int DWELL_W      = 16,
  parameter int XFER_CYCLES  = 64,
  parameter int HEAT_TIMEOUT = 4096,
  parameter int IDX_W        = $clog2(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_addr,
  input  logic [1:0]            cfg_type,
  input  logic [DWELL_W-1:0]    cfg_dwell,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_STAGES-1:0] temp_ok,
  output logic [NUM_STAGES-1:0] valve_open,
  output logic                  out_valve,
  output logic [NUM_STAGES-1:0] act_en,
  output logic                  busy,
  output logic [IDX_W-1:0]      cur_stage,
  output logic                  done,
  output logic                  fault
);

  localparam int MAXT = (XFER_CYCLES > HEAT_TIMEOUT) ? XFER_CYCLES : HEAT_TIMEOUT;
  localparam int CW   = $clog2(MAXT) + 1;
  localparam int TW   = (CW > DWELL_W) ? CW : DWELL_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);

  stage_cfg_t              cfg_tab [NUM_STAGES];
  stage_cfg_t              cur;
  seq_state_t              state, state_n;
  logic [IDX_W-1:0]        stage, stage_n;
  logic                    tload, texp, adv, accept, done_n;
  logic [TW-1:0]           tval;
  logic [NUM_STAGES-1:0]   sel_n;

  assign cur       = cfg_tab[stage];
  assign cur_stage = stage;

  seq_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tload),
    .load_val (tval),
    .expire   (texp)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_STAGES; i++)
        cfg_tab[i] <= '{stype: ST_BYPASS, dwell: '0};
    end else if (cfg_we && state == S_IDLE && 32'(cfg_addr) < NUM_STAGES) begin
      cfg_tab[cfg_addr] <= '{stype: stage_type_t'(cfg_type), dwell: CFG_DWELL_W'(cfg_dwell)};
    end
  end

  always_comb begin
    state_n = state;
    stage_n = stage;
    tload   = 1'b0;
    tval    = '0;
    adv     = 1'b0;
    accept  = 1'b0;
    done_n  = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        accept  = 1'b1;
        state_n = S_XFER;
        stage_n = '0;
        tload   = 1'b1;
        tval    = TW'(XFER_CYCLES);
      end
      S_XFER: if (texp) begin
        if (cur.stype == ST_HEAT) begin
          state_n = S_WAIT_TEMP;
          tload   = 1'b1;
          tval    = TW'(HEAT_TIMEOUT);
        end else if (cur.dwell != '0 && cur.stype != ST_BYPASS) begin
          state_n = S_DWELL;
          tload   = 1'b1;
          tval    = TW'(cur.dwell);
        end else begin
          adv = 1'b1;
        end
      end
      S_WAIT_TEMP: begin
        if (temp_ok[stage]) begin
          if (cur.dwell != '0) begin
            state_n = S_DWELL;
            tload   = 1'b1;
            tval    = TW'(cur.dwell);
          end else begin
            adv = 1'b1;
          end
        end else if (texp) begin
          state_n = S_FAULT;
        end
      end
      S_DWELL: if (texp) adv = 1'b1;
      S_DRAIN: if (texp) begin
        state_n = S_IDLE;
        done_n  = 1'b1;
      end
      S_FAULT: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    if (adv) begin
      tload = 1'b1;
      tval  = TW'(XFER_CYCLES);
      if (stage == LAST) begin
        state_n = S_DRAIN;
      end else begin
        state_n = S_XFER;
        stage_n = stage + 1'b1;
      end
    end

    // Abort overrides every transition decided above, including timer expiry.
    if (abort && state != S_IDLE) begin
      state_n = S_FAULT;
      stage_n = stage;
      tload   = 1'b0;
      done_n  = 1'b0;
    end

    sel_n = NUM_STAGES'(1) << stage_n;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      stage      <= '0;
      valve_open <= '0;
      out_valve  <= 1'b0;
      act_en     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state      <= state_n;
      stage      <= stage_n;
      valve_open <= (state_n == S_XFER) ? sel_n : '0;
      out_valve  <= (state_n == S_DRAIN);
      act_en     <= (state_n == S_WAIT_TEMP || state_n == S_DWELL) ? sel_n : '0;
      busy       <= (state_n != S_IDLE);
      done       <= done_n;
      if (state_n == S_FAULT)
        fault <= 1'b1;
      else if (accept)
        fault <= 1'b0;
    end
  end

endmodule
